ring_rr_arbiter: RTL

//   Round-robin arbiter that lets N requesters share one downstream resource
//   (e.g. the ring-counter LED datapath or a shared register bank).
//   A rotating one-hot priority pointer (a ring) decides who goes next.

---
 rtl/ring_rr_arbiter_pkg.sv | 22 ++
 rtl/ring_rr_arbiter_if.sv | 19 +
 rtl/ring_rr_arbiter_rr_pick.sv | 27 ++
 rtl/ring_rr_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 16;

    // Binary index of the set bit in a one-hot word (0 when the word is zero).
    function automatic int unsigned onehot2bin(input logic [31:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) r = r | unsigned'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Requester-side bus of the ring arbiter: requests in, one-hot grant out.
interface ring_rr_arbiter_if
    import ring_arb_pkg::*;
#(
    parameter int N = N_DEF
);
    localparam int GW = $clog2(N);

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [GW-1:0] gid;
    logic          busy;
    logic          timeout;

    modport master (output req, done, input grant, gid, busy, timeout);
    modport slave  (input req, done, output grant, gid, busy, timeout);

endinterface

// File: rtl/ring_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer position, wrapping around the top.
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] winner,
    output logic         valid
);
    int unsigned  p;
    logic [N-1:0] rot;
    logic [N-1:0] lsb;

    // Rotate so the pointer lands on bit 0, isolate the lowest set bit,
    // then rotate back into requester numbering.
    always_comb begin
        p      = onehot2bin(32'(ptr));
        rot    = N'({req, req} >> p);
        lsb    = rot & (~rot + N'(1));
        winner = N'({lsb, lsb} << p >> N);
        valid  = |req;
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority ring and a hold
// timeout; grants are held until done, request drop, or MAX_HOLD cycles.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    ring_rr_arbiter_if.slave  bus
);
    localparam int GW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [GW-1:0] gid_q, gid_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  pick_oh;
    logic          pick_vld;
    logic          rel_done, rel_drop, rel_tmo;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .valid  (pick_vld)
    );

    // Next-state: arbitrate in IDLE, count and watch release causes in GRANT.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        gid_d     = gid_q;
        timeout_d = 1'b0;
        rel_done  = bus.done;
        rel_drop  = ~|(bus.req & grant_q);
        rel_tmo   = (hold_q == HW'(MAX_HOLD - 1));
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    grant_d = pick_oh;
                    gid_d   = GW'(onehot2bin(32'(pick_oh)));
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_tmo) begin
                    // Hold counter is left at its final value; it is
                    // cleared again when the next grant is issued.
                    state_d   = IDLE;
                    grant_d   = '0;
                    gid_d     = '0;
                    ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
                    timeout_d = rel_tmo & ~rel_done & ~rel_drop;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset overrides any grant in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= N'(1);
            hold_q    <= '0;
            grant_q   <= '0;
            gid_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            gid_q     <= gid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.gid     = gid_q;
    assign bus.busy    = (state_q == GRANT);
    assign bus.timeout = timeout_q;

endmodule
